// File: rtl/alu_seq.sv
// alu_seq: handshaked ADD/SUB/MUL/MOD3 unit with a bit-serial mod-3 engine.
// Define ALU_SEQ_FLAGS_EN to build the {zero, carry, ovf} flag logic; otherwise flags reads 3'b000.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      opcode,
  input  logic [WIDTH-1:0]     num_1,
  input  logic [WIDTH-1:0]     num_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   ans,
  output logic                 err,
  output logic [2:0]           flags
);

  localparam int AW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_MOD3 = OP_W'(4'h8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // One MSB-first step of the residue recurrence r' = (2r + bit) mod 3.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] res;
    case ({r, b})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     ans_q, ans_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [1:0]        r_q, r_d, r_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  diff;
  logic [AW-1:0]     prod;

  assign sum       = {1'b0, num_1} + {1'b0, num_2};
  assign diff      = num_1 - num_2;
  assign prod      = AW'(num_1) * AW'(num_2);
  assign r_step    = mod3_step(r_q, sh_q[WIDTH-1]);

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign ans       = ans_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    ans_d   = ans_q;
    err_d   = err_q;
    sh_d    = sh_q;
    r_d     = r_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ans_d   = AW'(r_step);
          err_d   = 1'b0;
        end else begin
          r_d   = r_step;
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new accept overrides the DONE->IDLE return so results can stream.
    if (accept) begin
      case (opcode)
        OP_ADD: begin
          state_d = S_DONE;
          ans_d   = AW'(sum);
          err_d   = 1'b0;
        end
        OP_SUB: begin
          state_d = S_DONE;
          ans_d   = AW'(diff);
          err_d   = 1'b0;
        end
        OP_MUL: begin
          state_d = S_DONE;
          ans_d   = prod;
          err_d   = 1'b0;
        end
        OP_MOD3: begin
          state_d = S_BUSY;
          sh_d    = num_1;
          r_d     = 2'd0;
          cnt_d   = CNT_W'(WIDTH - 1);
        end
        default: begin
          state_d = S_DONE;
          ans_d   = '1;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ans_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ans_q   <= ans_d;
      err_q   <= err_d;
    end
  end

  // Serial engine datapath; an aborted run is discarded by the state reset.
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    r_q   <= r_d;
    cnt_q <= cnt_d;
  end

`ifdef ALU_SEQ_FLAGS_EN
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  logic [2:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (accept) begin
      case (opcode)
        OP_ADD:  flags_d = {ans_d == '0, sum[WIDTH],
                            add_ovf(num_1[WIDTH-1], num_2[WIDTH-1], sum[WIDTH-1])};
        OP_SUB:  flags_d = {ans_d == '0, num_1 < num_2,
                            sub_ovf(num_1[WIDTH-1], num_2[WIDTH-1], diff[WIDTH-1])};
        OP_MOD3: flags_d = flags_q;
        default: flags_d = {ans_d == '0, 2'b00};
      endcase
    end else if ((state_q == S_BUSY) && (cnt_q == '0)) begin
      flags_d = {ans_d == '0, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= 3'b000;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: doc/alu_seq.md
# alu_seq

Handshaked, parametrised successor to the 8-bit single-cycle ALU. It executes ADD, SUB, full-width MUL and MOD3 on WIDTH-bit unsigned operands behind valid/ready interfaces. MOD3 runs as a bit-serial multi-cycle unit, so no wide combinational mod-3 tree is needed. It sits between the operand/opcode sequencer and the result consumer; either side may stall.

## Interface
- WIDTH, default 8: operand width; legal range 4..32.
- OP_W, default 4: opcode width; fixed encoding in the low 4 bits, upper bits must be 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- opcode  in  OP_W  4'h1 ADD, 4'h2 SUB, 4'h4 MUL, 4'h8 MOD3; any other value is illegal.
- num_1, num_2  in  WIDTH  unsigned operands; MOD3 uses num_1 only.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- ans  out  2*WIDTH  result.
- err  out  1  illegal opcode for this result.
- flags  out  3  {zero, carry, ovf}; see Configuration.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: MOD3 in progress; in_ready=0.
  - DONE: out_valid=1.
- Accept: in_valid && in_ready at a rising edge; opcode and operands are captured.
- Transitions:
  - ADD, SUB, MUL or illegal opcode: IDLE -> DONE.
  - MOD3: IDLE -> BUSY; BUSY -> DONE after WIDTH bit-steps.
  - DONE with out_ready=1: -> IDLE; or, if a new op is accepted on the same edge, -> DONE/BUSY directly.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Arithmetic, all unsigned:
  - ADD: ans = zero-extended (WIDTH+1)-bit sum.
  - SUB: ans[WIDTH-1:0] = (num_1 - num_2) mod 2^WIDTH; upper bits 0.
  - MUL: ans = full 2*WIDTH product.
  - MOD3: ans[1:0] = num_1 mod 3; other bits 0. Computed MSB-first, one bit per cycle: r <= (2r + bit) mod 3, with r in {0,1,2}.
  - Illegal opcode: ans = all ones, err=1. err=0 for every legal op.
- ans, err and flags change only when a new result is loaded into DONE. They are stable while out_valid=1 and out_ready=0.
- Reset (rst_n=0 at an edge) wins over everything:
  - state -> IDLE; any in-flight MOD3 is aborted and discarded.
  - out_valid=0, ans=0, err=0, flags=0. in_ready=1 from the first edge after reset deasserts.

## Timing
- Single-cycle ops: accept at edge E -> out_valid=1 after E; latency 1.
- MOD3: accept at E -> out_valid=1 after E+WIDTH; latency WIDTH.
- Throughput:
  - Single-cycle ops with out_ready held at 1: one op per clock, with no bubble between results.
  - MOD3: one op per WIDTH+1 cycles at best.
- out_valid never drops without an out_ready handshake, except on reset.
- While in DONE, in_valid is ignored if out_ready=0.

## Configuration
- ALU_SEQ_FLAGS_EN defined:
  - zero: ans==0.
  - carry: ADD carry-out, or SUB borrow (num_1 < num_2).
  - ovf: signed two's-complement overflow for ADD/SUB on WIDTH bits.
  - For MUL, MOD3 and illegal opcodes: carry=0 and ovf=0; zero is still computed.
- ALU_SEQ_FLAGS_EN not defined: flags tied to 3'b000 and no flag logic is synthesised. The port list is identical in both builds.

## Test plan
- WIDTH=8, ADD 8'hFF+8'h01 -> out_valid 1 cycle after accept, ans=16'h0100. With flags enabled: zero=0, carry=1, ovf=0.
- SUB 8'h05-8'h07 -> ans=16'h00FE, carry=1; SUB 8'h80-8'h01 -> ans=16'h007F, ovf=1.
- MUL 8'hFF*8'hFF -> ans=16'hFE01. Hold out_ready=0 for 5 cycles: ans and out_valid stable, in_ready=0.
- MOD3 num_1=8'd200 -> out_valid exactly 8 cycles after accept, ans=16'h0002. Assert rst_n=0 at cycle 4 of a second MOD3 -> out_valid=0, ans=0, no result emitted.
- Opcode 4'h3 -> ans=16'hFFFF, err=1. The next legal ADD 1+1 -> ans=2, err=0.
- Back-to-back stream of 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
